ext_mem_responder: RTL

- Synthesizable off-chip memory slave on the downstream side of the HLS top's dual-channel master bus (Mout_* out, M_Rdata_ram/M_DataRdy back).
- Byte-wide storage, one byte lane per channel, programmable read/write latency, size-masked writes, address-window check and sticky protocol-error flags.
- A preload/dump side port lets the bench load input vectors and read back results without touching the master bus.

---
 rtl/ext_mem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: byte-wide off-chip memory model serving a dual-channel
// master bus. Each channel runs its own IDLE/RD/WR handshake with a
// programmable latency. Writes can be masked by access size. Accesses outside
// the address window and oe/we collisions raise sticky error flags.
// A side port preloads the array and reads it back combinationally.
module ext_mem_responder #(
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0,
    parameter int MEMSIZE   = 64,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [15:0]           Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    output logic [15:0]           M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  init_we,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [7:0]            init_data,
    output logic [7:0]            dbg_data,
    output logic                  err_both,
    output logic                  err_oob
);
    localparam int          DEPTH   = 1 << ADDR_W;
    localparam int          PIPE    = READ_LAT - 1;
    localparam logic [31:0] WIN_LO  = 32'(BASE_ADDR);
    localparam logic [31:0] WIN_SZ  = 32'(MEMSIZE);
    localparam logic [7:0]  RD_LAST = 8'(READ_LAT - 1);
    localparam logic [7:0]  WR_LAST = 8'(WRITE_LAT - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    // Array spans the full address space so any ADDR_W-bit offset indexes it
    logic [7:0]             mem_q [DEPTH];
    logic [1:0]             wr_en;
    logic [1:0]             inr_v;
    logic [1:0][ADDR_W-1:0] wr_off;
    logic [1:0][7:0]        wr_byte;
    logic                   err_both_q, err_both_d;
    logic                   err_oob_q, err_oob_d;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic              oe, we, inr, rd_start, rd_rdy, wr_rdy;
            logic [ADDR_W-1:0] addr, off, wr_addr;
            logic [31:0]       off32;
            logic [7:0]        wdata, mask;
            logic [3:0]        size;
            state_t            state_q, state_d;
            logic [7:0]        cnt_q, cnt_d;
            logic [ADDR_W-1:0] addr_q, addr_d;
            logic [7:0]        pipe_q [PIPE];
            logic [7:0]        pipe_d [PIPE];

            assign oe    = Mout_oe_ram[gi];
            assign we    = Mout_we_ram[gi];
            assign addr  = Mout_addr_ram[gi*ADDR_W +: ADDR_W];
            assign wdata = Mout_Wdata_ram[gi*8 +: 8];
            assign size  = Mout_data_ram_size[gi*4 +: 4];

            // Unsigned wrap puts addresses below the base far above the window
            assign off32    = 32'(addr) - WIN_LO;
            assign inr      = off32 < WIN_SZ;
            assign off      = off32[ADDR_W-1:0];
            assign rd_start = (state_q == S_IDLE) && oe && !we && inr;

            // State register: channel state, latency counter, sampled offset
            always_ff @(posedge clock) begin
                if (!reset) begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                    addr_q  <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    addr_q  <= addr_d;
                end
            end

            // Next state: count while the enable holds, abort when it drops or collides
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                addr_d  = addr_q;
                case (state_q)
                    S_IDLE: begin
                        cnt_d  = 8'd0;
                        addr_d = off;
                        if (oe && !we && inr) begin
                            state_d = S_RD;
                            cnt_d   = 8'd1;
                        end else if (we && !oe && inr && (cnt_q != WR_LAST)) begin
                            state_d = S_WR;
                            cnt_d   = 8'd1;
                        end
                    end
                    S_RD: begin
                        if (oe && !we && (cnt_q != RD_LAST)) begin
                            cnt_d = cnt_q + 8'd1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = 8'd0;
                        end
                    end
                    S_WR: begin
                        if (we && !oe && (cnt_q != WR_LAST)) begin
                            cnt_d = cnt_q + 8'd1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = 8'd0;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                endcase
            end

            // Outputs: completion strobes, write target and size mask
            always_comb begin
                rd_rdy  = reset && (state_q == S_RD) && oe && !we && (cnt_q == RD_LAST);
                // In IDLE the counter is 0, so a single-cycle write completes at once
                wr_rdy  = reset && we && !oe && (cnt_q == WR_LAST) &&
                          ((state_q == S_WR) || ((state_q == S_IDLE) && inr));
                wr_addr = (state_q == S_IDLE) ? off : addr_q;
                mask    = (size >= 4'd8) ? 8'hFF : (8'hFF >> (4'd8 - size));
            end

            // Read pipeline input: capture on the request's first edge, else shift zeros in
            always_comb begin
                pipe_d[0] = rd_start ? mem_q[off] : 8'h00;
                for (int i = 1; i < PIPE; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Read pipeline register
            always_ff @(posedge clock) begin
                for (int i = 0; i < PIPE; i++) begin
                    pipe_q[i] <= reset ? pipe_d[i] : 8'h00;
                end
            end

            assign inr_v[gi]   = inr;
            assign wr_en[gi]   = wr_rdy;
            assign wr_off[gi]  = wr_addr;
            assign wr_byte[gi] = (wdata & mask) | (mem_q[wr_addr] & ~mask);

            assign M_DataRdy[gi]          = rd_rdy | wr_rdy;
            assign M_Rdata_ram[gi*8 +: 8] = rd_rdy ? pipe_q[PIPE-1] : 8'h00;
        end
    endgenerate

    // Sticky error flags accumulate until reset
    always_comb begin
        err_both_d = err_both_q | (|(Mout_oe_ram & Mout_we_ram));
        err_oob_d  = err_oob_q  | (|((Mout_oe_ram | Mout_we_ram) & ~inr_v));
    end

    // Error flag registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_both_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            err_both_q <= err_both_d;
            err_oob_q  <= err_oob_d;
        end
    end

    // Memory writes, not reset; later statements win: ch0, then ch1, then preload
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_en[c]) begin
                mem_q[wr_off[c]] <= wr_byte[c];
            end
        end
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
    end

    assign dbg_data = mem_q[init_addr];
    assign err_both = err_both_q;
    assign err_oob  = err_oob_q;
endmodule
